// File: rtl/phy_rx_pkg.sv
// Shared constants and link-width legalisation for the lane deskew receive path.
package phy_rx_pkg;

  localparam int BYTE_W     = 8;
  localparam int LANE_IDX_W = 8;

  // Widths of zero, non-powers of two, or wider than the PHY fall back to x1.
  function automatic logic [LANE_IDX_W-1:0] legal_width(input logic [LANE_IDX_W-1:0] req,
                                                        input int num_lanes);
    logic [LANE_IDX_W-1:0] w;
    w = req;
    if ((req == '0) || ((req & (req - LANE_IDX_W'(1))) != '0) || (int'(req) > num_lanes)) begin
      w = LANE_IDX_W'(1);
    end
    return w;
  endfunction

endpackage

// File: rtl/phy_rx_lane_fifo.sv
// Single-clock byte FIFO for one lane; data visible the cycle after the push.
// A full FIFO accepts a push only when it pops in the same cycle.
module phy_rx_lane_fifo
  import phy_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] din_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  always_comb begin
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
    dout_o  = mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_f) begin
    if (!reset && do_push) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/phy_rx_lane_deskew.sv
// Deskews, unstripes and packs active lanes into OUT_BYTES words; one cycle from FIFO write to word.
// A blocked output register stalls column pops, so lane FIFOs fill and then flag overflow.
module phy_rx_lane_deskew
  import phy_rx_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int OUT_BYTES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_f,
  input  logic                            reset,
  input  logic [$clog2(NUM_LANES):0]      active_lanes,
  input  logic [BYTE_W*NUM_LANES-1:0]     data_in,
  input  logic [NUM_LANES-1:0]            valid_in,
  input  logic                            ready_in,
  output logic [BYTE_W*OUT_BYTES-1:0]     data_out,
  output logic                            valid_out,
  output logic [NUM_LANES-1:0]            overflow
);

  localparam int CNT_W = $clog2(OUT_BYTES + 1);

  logic [LANE_IDX_W-1:0]         w_q;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [BYTE_W*OUT_BYTES-1:0]   asm_q, asm_d, data_q, data_d, word_nxt;
  logic                          valid_q, valid_d;
  logic [NUM_LANES-1:0]          ovf_q, ovf_d;

  logic [NUM_LANES-1:0]          lane_act, lane_push, lane_pop, fifo_full, fifo_empty;
  logic [BYTE_W-1:0]             fifo_dout [NUM_LANES];
  logic                          col_rdy, completes, can_adv, col_pop;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    phy_rx_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_f   (clk_f),
      .reset   (reset),
      .push_i  (lane_push[g]),
      .din_i   (data_in[BYTE_W*g +: BYTE_W]),
      .pop_i   (lane_pop[g]),
      .dout_o  (fifo_dout[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

  always_comb begin
    col_rdy = 1'b1;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_act[i] = (int'(w_q) > i);
      if (lane_act[i] && fifo_empty[i]) col_rdy = 1'b0;
    end

    completes = ((int'(cnt_q) + int'(w_q)) == OUT_BYTES);
    can_adv   = !completes || !valid_q || ready_in;
    col_pop   = col_rdy && can_adv;

    lane_pop  = {NUM_LANES{col_pop}} & lane_act;
    lane_push = valid_in & lane_act;

    // Lane j of the column lands at byte position cnt_q + j of the word being built.
    word_nxt = asm_q;
    for (int b = 0; b < OUT_BYTES; b++) begin
      for (int j = 0; j < NUM_LANES; j++) begin
        if (lane_act[j] && ((int'(cnt_q) + j) == b)) begin
          word_nxt[BYTE_W*b +: BYTE_W] = fifo_dout[j];
        end
      end
    end

    cnt_d   = cnt_q;
    asm_d   = asm_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q | (lane_push & fifo_full & ~lane_pop);

    if (valid_q && ready_in) valid_d = 1'b0;

    if (col_pop) begin
      if (completes) begin
        data_d  = word_nxt;
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        asm_d = word_nxt;
        cnt_d = CNT_W'(int'(cnt_q) + int'(w_q));
      end
    end
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      w_q     <= legal_width(LANE_IDX_W'(active_lanes), NUM_LANES);
      cnt_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign overflow  = ovf_q;

endmodule
